// File: rtl/servo_seq_loader_if.sv
// Byte-stream handshake between the host/UART side and the sequence loader.
//   rx_data  : incoming byte
//   rx_valid : rx_data is valid
//   rx_ready : loader can accept a byte this cycle
// A byte transfers on a rising clock edge with rx_valid & rx_ready.
// master = byte source, slave = loader.
interface servo_seq_loader_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready
    );
endinterface

// File: rtl/servo_seq_loader.sv
// Upstream feeder for the servo sequencer RAM. Parses a framed byte stream
//   SYNC, N, {HI, LO} x (N+1), CHK
// validates it (HI upper bits zero, 8-bit sum of N..CHK == 0, inter-byte timeout)
// and writes {speed, pos} words into the position/speed RAM. Addresses above N are
// padded with the last entry so the servo holds its final position. The servo stage
// is held in reset from SYNC until a frame is fully accepted.
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   rx                  : byte-stream handshake (slave side)
//   wr_en/wr_addr/wr_data : RAM write port, registered
//   servo_rst           : active-high reset to the servo stage
//   load_busy           : frame in progress
//   load_done/load_err  : one-cycle pulses, frame accepted / rejected
module servo_seq_loader #(
    parameter int unsigned ADDR_LEN          = 8,
    parameter int unsigned POSITION_DATA_LEN = 8,
    parameter int unsigned SPEED_DATA_LEN    = 5,
    parameter int unsigned DATA_LEN          = SPEED_DATA_LEN + POSITION_DATA_LEN,
    parameter int unsigned MAX_RAM_POS       = 256,
    parameter logic [7:0]  SYNC_BYTE         = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES    = 1000000
) (
    input  logic                 clk,
    input  logic                 rst,
    servo_seq_loader_if.slave    rx,
    output logic                 wr_en,
    output logic [ADDR_LEN-1:0]  wr_addr,
    output logic [DATA_LEN-1:0]  wr_data,
    output logic                 servo_rst,
    output logic                 load_busy,
    output logic                 load_done,
    output logic                 load_err
);
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_LEN-1:0] LastAddr = ADDR_LEN'(MAX_RAM_POS - 1);

    typedef enum logic [2:0] {
        StIdle, StCount, StHi, StLo, StChk, StPad, StDone, StErr
    } state_e;

    state_e                       state_q;
    logic [ADDR_LEN-1:0]          n_q;
    logic [ADDR_LEN-1:0]          idx_q;
    logic [7:0]                   sum_q;
    logic [SPEED_DATA_LEN-1:0]    speed_q;
    logic [POSITION_DATA_LEN-1:0] pos_q;
    logic [TmoW-1:0]              tmo_q;

    logic       accept;
    logic       counting;
    logic [7:0] sum_next;

    always_comb begin
        rx.rx_ready = 1'b0;
        counting    = 1'b0;
        unique case (state_q)
            StIdle:                     rx.rx_ready = 1'b1;
            StCount, StHi, StLo, StChk: begin
                rx.rx_ready = 1'b1;
                counting    = 1'b1;
            end
            default:                    rx.rx_ready = 1'b0;
        endcase
    end

    assign accept   = rx.rx_valid & rx.rx_ready;
    assign sum_next = sum_q + rx.rx_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            n_q       <= '0;
            idx_q     <= '0;
            sum_q     <= '0;
            speed_q   <= '0;
            pos_q     <= '0;
            tmo_q     <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            servo_rst <= 1'b1;
            load_busy <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            wr_en     <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;

            // Idle-gap counter: only runs while waiting for bytes inside a frame.
            if (accept || !counting) begin
                tmo_q <= '0;
            end else begin
                tmo_q <= tmo_q + TmoW'(1);
            end

            unique case (state_q)
                StIdle: begin
                    if (accept && rx.rx_data == SYNC_BYTE) begin
                        state_q   <= StCount;
                        servo_rst <= 1'b1;
                        load_busy <= 1'b1;
                    end
                end
                StCount: begin
                    if (accept) begin
                        n_q     <= ADDR_LEN'(rx.rx_data);
                        idx_q   <= '0;
                        sum_q   <= rx.rx_data;
                        state_q <= StHi;
                    end
                end
                StHi: begin
                    if (accept) begin
                        if (rx.rx_data[7:SPEED_DATA_LEN] != '0) begin
                            state_q  <= StErr;
                            load_err <= 1'b1;
                        end else begin
                            speed_q <= rx.rx_data[SPEED_DATA_LEN-1:0];
                            sum_q   <= sum_next;
                            state_q <= StLo;
                        end
                    end
                end
                StLo: begin
                    if (accept) begin
                        pos_q   <= rx.rx_data[POSITION_DATA_LEN-1:0];
                        sum_q   <= sum_next;
                        wr_en   <= 1'b1;
                        wr_addr <= idx_q;
                        wr_data <= {speed_q, rx.rx_data[POSITION_DATA_LEN-1:0]};
                        if (idx_q == n_q) begin
                            state_q <= StChk;
                        end else begin
                            idx_q   <= idx_q + ADDR_LEN'(1);
                            state_q <= StHi;
                        end
                    end
                end
                StChk: begin
                    if (accept) begin
                        if (sum_next != 8'h00) begin
                            state_q  <= StErr;
                            load_err <= 1'b1;
                        end else if (n_q == LastAddr) begin
                            state_q   <= StDone;
                            load_done <= 1'b1;
                        end else begin
                            // N < LastAddr here, so N+1 cannot wrap.
                            idx_q   <= n_q + ADDR_LEN'(1);
                            state_q <= StPad;
                        end
                    end
                end
                StPad: begin
                    wr_en   <= 1'b1;
                    wr_addr <= idx_q;
                    wr_data <= {speed_q, pos_q};
                    if (idx_q == LastAddr) begin
                        state_q   <= StDone;
                        load_done <= 1'b1;
                    end else begin
                        idx_q <= idx_q + ADDR_LEN'(1);
                    end
                end
                StDone: begin
                    servo_rst <= 1'b0;
                    load_busy <= 1'b0;
                    state_q   <= StIdle;
                end
                StErr: begin
                    // servo_rst stays asserted until a later good frame.
                    load_busy <= 1'b0;
                    state_q   <= StIdle;
                end
                default: state_q <= StIdle;
            endcase

            if (counting && !accept && tmo_q == TmoLast) begin
                state_q  <= StErr;
                load_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_servo_seq_loader.sv
// Self-checking bench for servo_seq_loader: hand-written corner sequences, a table of
// frame recipes and randomized frames, all checked against a frame-level reference model.
module tb_servo_seq_loader;
    localparam int TMO = 300;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [12:0] wr_data;
    logic        servo_rst;
    logic        load_busy;
    logic        load_done;
    logic        load_err;

    always #5 clk = ~clk;

    servo_seq_loader_if rx_if ();

    servo_seq_loader #(
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx_if),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .servo_rst (servo_rst),
        .load_busy (load_busy),
        .load_done (load_done),
        .load_err  (load_err)
    );

    // Write and pulse monitor, sampled on the falling edge.
    logic [7:0]  wa_q[$];
    logic [12:0] wd_q[$];
    int          done_cnt = 0;

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wa_q.push_back(wr_addr);
            wd_q.push_back(wr_data);
        end
        if (load_done === 1'b1) done_cnt <= done_cnt + 1;
    end

    int          n_chk = 0;
    int          n_err = 0;
    bit          rand_gaps = 1'b0;
    logic [7:0]  frame_q[$];
    logic [12:0] exp_ram[256];

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    // Reference model: parse frame_q as the loader should; fills exp_ram on success.
    function automatic bit model_frame();
        int          p = 0;
        logic [7:0]  n, hi, lo, s;
        logic [12:0] ent[$];
        while (p < frame_q.size() && frame_q[p] != 8'hA5) p++;
        if (p + 1 >= frame_q.size()) return 1'b0;
        p++;
        n = frame_q[p];
        p++;
        s = n;
        for (int i = 0; i <= int'(n); i++) begin
            if (p >= frame_q.size()) return 1'b0;
            hi = frame_q[p];
            p++;
            if (hi[7:5] != 3'b000) return 1'b0;
            if (p >= frame_q.size()) return 1'b0;
            lo = frame_q[p];
            p++;
            s = s + hi + lo;
            ent.push_back({hi[4:0], lo});
        end
        if (p >= frame_q.size()) return 1'b0;
        s = s + frame_q[p];
        if (s != 8'h00) return 1'b0;
        for (int a = 0; a < 256; a++) exp_ram[a] = (a <= int'(n)) ? ent[a] : ent[n];
        return 1'b1;
    endfunction

    task automatic gen_frame(input int n, input bit bad_chk, input int bad_hi,
                             input int garbage);
        logic [7:0] b, hi, lo, s;
        frame_q.delete();
        repeat (garbage) begin
            b = 8'($urandom);
            if (b == 8'hA5) b = 8'h00;
            frame_q.push_back(b);
        end
        frame_q.push_back(8'hA5);
        frame_q.push_back(8'(n));
        s = 8'(n);
        for (int i = 0; i <= n; i++) begin
            hi = {3'b000, 5'($urandom)};
            if (i == bad_hi) begin
                hi[7:5] = 3'($urandom_range(1, 7));
                frame_q.push_back(hi);
                return;
            end
            lo = 8'($urandom);
            frame_q.push_back(hi);
            frame_q.push_back(lo);
            s = s + hi + lo;
        end
        b = 8'h00 - s;
        if (bad_chk) b = b + 8'($urandom_range(1, 255));
        frame_q.push_back(b);
    endtask

    // Entered and left in the low clock phase.
    task automatic send_byte(input logic [7:0] b);
        int k = 0;
        bit acc = 1'b0;
        if (rand_gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
        rx_if.rx_data  = b;
        rx_if.rx_valid = 1'b1;
        while (!acc && k < 1000) begin
            acc = rx_if.rx_ready;
            @(negedge clk);
            k++;
        end
        rx_if.rx_valid = 1'b0;
        rx_if.rx_data  = 8'($urandom);
        if (!acc) check("accept_timeout", 32'(acc), 32'd1);
    endtask

    task automatic wait_outcome(output bit d, output bit e, output bit sp, output bit sa);
        int k = 0;
        while (load_done !== 1'b1 && load_err !== 1'b1 && k < 800) begin
            @(negedge clk);
            k++;
        end
        d  = (load_done === 1'b1);
        e  = (load_err === 1'b1);
        sp = servo_rst;
        @(negedge clk);
        sa = servo_rst;
    endtask

    task automatic check_image(input string tag, input int s);
        int cnt = wa_q.size() - s;
        int bad = 0;
        check({tag, "_wr_count"}, 32'(cnt), 32'd256);
        if (cnt >= 256) begin
            for (int i = 0; i < 256; i++) begin
                if (wa_q[s+i] !== 8'(i) || wd_q[s+i] !== exp_ram[i]) begin
                    if (bad == 0)
                        $display("  %s first bad write #%0d: addr %0h data %0h, want %0h %0h",
                                 tag, i, wa_q[s+i], wd_q[s+i], i, exp_ram[i]);
                    bad++;
                end
            end
        end
        check({tag, "_ram_image"}, 32'(bad), 32'd0);
    endtask

    task automatic run_frame(input string tag, input bit exp_ok, output int s);
        bit d, e, sp, sa, m;
        #1;
        s = wa_q.size();
        for (int i = 0; i < frame_q.size(); i++) send_byte(frame_q[i]);
        wait_outcome(d, e, sp, sa);
        check({tag, "_done"}, 32'(d), 32'(exp_ok));
        check({tag, "_err"}, 32'(e), 32'(!exp_ok));
        check({tag, "_servo_rst"}, 32'(sa), 32'(!exp_ok));
        check({tag, "_busy"}, 32'(load_busy), 32'd0);
        if (exp_ok) begin
            m = model_frame();
            #1;
            check_image(tag, s);
        end
    endtask

    typedef struct {
        int n;
        bit bad_chk;
        int bad_hi;
        int garbage;
        bit exp_ok;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int  s, c, e0, d0;
        bit  d, e, sp, sa, ok;

        vecs[0] = '{n: 0,   bad_chk: 1'b0, bad_hi: -1, garbage: 0, exp_ok: 1'b1};
        vecs[1] = '{n: 255, bad_chk: 1'b0, bad_hi: -1, garbage: 0, exp_ok: 1'b1};
        vecs[2] = '{n: 1,   bad_chk: 1'b0, bad_hi: -1, garbage: 3, exp_ok: 1'b1};
        vecs[3] = '{n: 7,   bad_chk: 1'b1, bad_hi: -1, garbage: 2, exp_ok: 1'b0};
        vecs[4] = '{n: 5,   bad_chk: 1'b0, bad_hi: 3,  garbage: 0, exp_ok: 1'b0};
        vecs[5] = '{n: 254, bad_chk: 1'b0, bad_hi: -1, garbage: 1, exp_ok: 1'b1};
        vecs[6] = '{n: 100, bad_chk: 1'b1, bad_hi: -1, garbage: 0, exp_ok: 1'b0};

        rst = 1'b0;
        rx_if.rx_valid = 1'b0;
        rx_if.rx_data  = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_busy", 32'(load_busy), 32'd0);
        check("rst_done", 32'(load_done), 32'd0);
        check("rst_err", 32'(load_err), 32'd0);
        check("rst_servo_rst", 32'(servo_rst), 32'd1);
        check("rst_rx_ready", 32'(rx_if.rx_ready), 32'd1);
        rst = 1'b1;
        @(negedge clk);

        // Good 2-entry frame with PAD to 255.
        frame_q = {8'hA5, 8'h01, 8'h0A, 8'h80, 8'h1F, 8'hFF, 8'h57};
        run_frame("two_entry", 1'b1, s);
        check("two_w0_addr", 32'(wa_q[s]), 32'h00);
        check("two_w0_data", 32'(wd_q[s]), 32'h0A80);
        check("two_w1_data", 32'(wd_q[s+1]), 32'h1FFF);
        check("two_w2_addr", 32'(wa_q[s+2]), 32'h02);
        check("two_w255_data", 32'(wd_q[s+255]), 32'h1FFF);

        // servo_rst falls the cycle after the load_done pulse.
        frame_q = {8'hA5, 8'h01, 8'h0A, 8'h80, 8'h1F, 8'hFF, 8'h57};
        for (int i = 0; i < frame_q.size(); i++) send_byte(frame_q[i]);
        wait_outcome(d, e, sp, sa);
        check("rel_done", 32'(d), 32'd1);
        check("rel_srst_at_pulse", 32'(sp), 32'd1);
        check("rel_srst_after", 32'(sa), 32'd0);
        check("rel_done_one_cycle", 32'(load_done), 32'd0);

        // Bad checksum, then a good frame releases the servo.
        frame_q = {8'hA5, 8'h01, 8'h0A, 8'h80, 8'h1F, 8'hFF, 8'h58};
        run_frame("bad_chk", 1'b0, s);
        frame_q = {8'hA5, 8'h01, 8'h0A, 8'h80, 8'h1F, 8'hFF, 8'h57};
        run_frame("after_bad", 1'b1, s);

        // Illegal HI byte: ERR straight after the HI accept, nothing written.
        #1;
        s = wa_q.size();
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h20);
        check("ill_err_pulse", 32'(load_err), 32'd1);
        check("ill_ready_low", 32'(rx_if.rx_ready), 32'd0);
        @(negedge clk);
        check("ill_ready_high", 32'(rx_if.rx_ready), 32'd1);
        check("ill_err_cleared", 32'(load_err), 32'd0);
        check("ill_servo_rst", 32'(servo_rst), 32'd1);
        #1;
        check("ill_no_write", 32'(wa_q.size() - s), 32'd0);

        // No timeout while idle.
        c = 0;
        repeat (2 * TMO) begin
            @(negedge clk);
            if (load_err === 1'b1) c++;
        end
        check("idle_no_timeout", 32'(c), 32'd0);

        // Stall after A5,03: timeout about TMO cycles after the last byte.
        send_byte(8'hA5);
        send_byte(8'h03);
        c = 0;
        while (load_err !== 1'b1 && c < 3 * TMO) begin
            @(negedge clk);
            c++;
        end
        check("tmo_fired", 32'(load_err), 32'd1);
        check("tmo_window", 32'(c >= TMO - 2 && c <= TMO + 2), 32'd1);
        if (c < TMO - 2 || c > TMO + 2) $display("  timeout after %0d cycles", c);

        // Leading garbage is dropped.
        frame_q = {8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h0A, 8'h80, 8'h1F, 8'hFF, 8'h57};
        run_frame("garbage", 1'b1, s);

        // Async reset during PAD at address 100.
        frame_q = {8'hA5, 8'h01, 8'h0A, 8'h80, 8'h1F, 8'hFF, 8'h57};
        for (int i = 0; i < frame_q.size(); i++) send_byte(frame_q[i]);
        c = 0;
        while (!(wr_en === 1'b1 && wr_addr == 8'd100) && c < 400) begin
            @(negedge clk);
            c++;
        end
        check("pad_reached_100", 32'(wr_addr), 32'd100);
        check("pad_busy", 32'(load_busy), 32'd1);
        check("pad_ready_low", 32'(rx_if.rx_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("pad_rst_wr_en", 32'(wr_en), 32'd0);
        check("pad_rst_servo_rst", 32'(servo_rst), 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        s  = wa_q.size();
        d0 = done_cnt;
        repeat (300) @(negedge clk);
        #1;
        check("pad_rst_no_writes", 32'(wa_q.size() - s), 32'd0);
        check("pad_rst_no_done", 32'(done_cnt - d0), 32'd0);
        check("pad_rst_idle_ready", 32'(rx_if.rx_ready), 32'd1);
        check("pad_rst_servo_hold", 32'(servo_rst), 32'd1);

        // Table of frame recipes with randomized gaps and payload.
        rand_gaps = 1'b1;
        for (int v = 0; v < 7; v++) begin
            gen_frame(vecs[v].n, vecs[v].bad_chk, vecs[v].bad_hi, vecs[v].garbage);
            run_frame($sformatf("vec%0d", v), vecs[v].exp_ok, s);
        end

        // Fully random frames, outcome from the model.
        for (int r = 0; r < 8; r++) begin
            e0 = int'($urandom_range(0, 3));
            c  = int'($urandom_range(0, 255));
            gen_frame(c, e0 == 0, (e0 == 1) ? int'($urandom_range(0, c)) : -1,
                      int'($urandom_range(0, 3)));
            ok = model_frame();
            run_frame($sformatf("rnd%0d", r), ok, s);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/servo_seq_loader.md
Name: servo_seq_loader

Overview:
- Upstream feeder for the servo sequencer RAM.
- Receives a framed byte stream (UART/host side) over a valid/ready handshake and validates it.
- Writes 13-bit {speed[4:0], pos[7:0]} entries into the position/speed RAM that the servo stage walks by address.
- Holds the servo stage in reset while loading; releases it only after a fully checksummed frame plus tail padding.

Parameters:
- ADDR_LEN, 8, RAM address width.
- DATA_LEN, 13, RAM word width = SPEED_DATA_LEN + POSITION_DATA_LEN.
- POSITION_DATA_LEN, 8, position field width (wr_data[7:0]).
- SPEED_DATA_LEN, 5, speed field width (wr_data[12:8]).
- MAX_RAM_POS, 256, number of RAM entries.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 1000000, max idle cycles between bytes inside a frame (20 ms at 50 MHz).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  reset; asynchronous, active-low.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  loader can accept a byte.
- wr_en  out  1  RAM write strobe.
- wr_addr  out  ADDR_LEN  RAM write address.
- wr_data  out  DATA_LEN  RAM write data.
- servo_rst  out  1  active-high reset to servo stage.
- load_busy  out  1  frame in progress.
- load_done  out  1  one-cycle pulse, frame accepted.
- load_err  out  1  one-cycle pulse, frame rejected.

Behaviour:
- **Reset.** While rst is low, state is IDLE immediately (async) and outputs are:
  - wr_en, wr_addr, wr_data, load_busy, load_done, load_err = 0
  - servo_rst = 1
- **Handshake.** A byte is accepted on a rising clk edge with rx_valid & rx_ready. rx_ready is a combinational state decode:
  - 1 in IDLE, COUNT, HI, LO, CHK
  - 0 in PAD, DONE, ERR
- **Frame format.** SYNC_BYTE, then N (entries = N+1, range 1..256), then N+1 pairs {HI = 3'b000,speed[4:0]; LO = pos[7:0]}, then CHK.
- **Checksum.** The 8-bit sum mod 256 of N, all HI/LO bytes and CHK must equal 8'h00.
- **IDLE.** Non-SYNC bytes are accepted and dropped. On SYNC: go to COUNT; set servo_rst=1 and load_busy=1.
- **COUNT.** Latch N; clear index; seed running sum with N; go to HI.
- **HI.**
  - If rx_data[7:5] != 0, go to ERR.
  - Otherwise latch speed and go to LO.
- **LO.** Latch pos. In the cycle after acceptance, register wr_en=1, wr_addr=index, wr_data={speed,pos} (1-cycle write latency; wr_en is high for exactly one cycle). Then:
  - if index == N: go to CHK
  - else: index+1, go to HI
- **CHK.** Add CHK to the sum.
  - If the sum is nonzero, go to ERR.
  - If the sum is zero and N == MAX_RAM_POS-1, go to DONE.
  - Otherwise go to PAD.
- **PAD.** Write the last entry's {speed,pos} to addresses N+1..MAX_RAM_POS-1, one per cycle, wr_en high continuously. After the write to MAX_RAM_POS-1, go to DONE. This keeps the servo holding its final position once its address counter saturates.
- **DONE.** Pulse load_done for 1 cycle. servo_rst=0 and load_busy=0 from the next cycle. Return to IDLE.
- **ERR.** Pulse load_err for 1 cycle. load_busy=0 next cycle. servo_rst stays 1 until a later successful frame. Return to IDLE.
- **RAM after error.** RAM contents after an error are undefined (partial writes are not rolled back).
- **Timeout.**
  - A counter clears on every accepted byte and counts only in COUNT/HI/LO/CHK.
  - Reaching TIMEOUT_CYCLES-1 with no byte goes to ERR.
  - The counter does not run in IDLE.
- **SYNC_BYTE mid-frame** is ordinary data; there is no resync.
- **Async reset mid-frame or mid-PAD:**
  - wr_en drops at once and no further writes occur.
  - servo_rst=1; IDLE on release.
- **Widths.** index is ADDR_LEN bits; N=255 yields 256 entries with no PAD phase; wrap is impossible.

Test Plan:
- **Good 2-entry frame.** Send A5,01,0A,80,1F,FF,57 ->
  - writes 0:13'h0A80, 1:13'h1FFF
  - then 254 PAD writes of 13'h1FFF at 2..255
  - load_done one pulse; servo_rst 1->0 the cycle after.
- **Full 256-entry frame.** N=FF ->
  - exactly 256 writes at addresses 0..255, no PAD writes
  - load_done pulses; index never wraps.
- **Bad checksum.** Same frame as the first scenario with CHK=58 ->
  - load_err pulse; servo_rst stays 1; load_done never asserts
  - next good frame releases servo_rst.
- **Illegal HI byte.** A5,00,20 -> ERR immediately after HI accept; no write issued; rx_ready low one cycle then high in IDLE.
- **Timeout and garbage.**
  - Stall 1000000 cycles after A5,03 -> load_err.
  - Leading bytes 00,FF,5A before A5 -> dropped, frame loads normally.
- **Reset and backpressure.**
  - Assert rst low during PAD at address 100 -> wr_en 0 same cycle; servo_rst 1; no further writes.
  - Toggle rx_valid randomly during a frame -> identical RAM image.
